// File: rtl/fifo_record_sequencer_if.sv
// Record handshake bundle between the FIFO, the sequencer and the consumer.
//   fifo_empty   : FIFO holds less than one full record
//   fifo_data    : record at the FIFO read position (combinational)
//   fifo_read_en : dequeue strobe to the FIFO
//   rec_valid    : rec_data holds an undelivered record
//   rec_data     : registered record presented to the consumer
//   rec_ready    : consumer accepts rec_data this cycle
// master = sequencer side, slave = FIFO/consumer side.
interface fifo_record_sequencer_if #(
  parameter int unsigned WordSize    = 8,
  parameter int unsigned RecordWords = 16
);
  localparam int unsigned RecordSizeBits = WordSize * RecordWords;

  logic                      fifo_empty;
  logic [RecordSizeBits-1:0] fifo_data;
  logic                      fifo_read_en;
  logic                      rec_valid;
  logic [RecordSizeBits-1:0] rec_data;
  logic                      rec_ready;

  modport master (
    input  fifo_empty, fifo_data, rec_ready,
    output fifo_read_en, rec_valid, rec_data
  );

  modport slave (
    output fifo_empty, fifo_data, rec_ready,
    input  fifo_read_en, rec_valid, rec_data
  );
endinterface

// File: rtl/fifo_record_sequencer.sv
// Pulls whole records out of a FIFO and presents them one at a time to a
// consumer with a valid/ready handshake; back-to-back delivery without
// bubbles. Also keeps saturating statistics counters.
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   enable       : allows new records to be fetched
//   bus          : record handshake bundle (master side)
//   busy         : high while a record is held
//   rec_count    : records delivered since reset (saturating)
//   starve_count : cycles the consumer could take a record but the FIFO was
//                  empty, counted only after the first delivery (saturating)
module fifo_record_sequencer #(
  parameter int unsigned WordSize    = 8,
  parameter int unsigned RecordWords = 16,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  fifo_record_sequencer_if.master       bus,
  output logic                          busy,
  output logic [CountWidth-1:0]         rec_count,
  output logic [CountWidth-1:0]         starve_count
);
  localparam int unsigned RecordSizeBits = WordSize * RecordWords;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [RecordSizeBits-1:0] rec_data_q;
  logic [CountWidth-1:0]     rec_count_q;
  logic [CountWidth-1:0]     starve_count_q;
  logic                      take;
  logic                      deliver;
  logic                      starve;
  logic                      slot_free;

  always_comb begin
    state_d   = state_q;
    slot_free = (state_q == IDLE) || bus.rec_ready;
    // reset gates the strobe so a reset cycle never consumes a FIFO word
    take      = enable && !bus.fifo_empty && !reset && slot_free;
    deliver   = (state_q == PRESENT) && bus.rec_ready;
    starve    = enable && bus.fifo_empty && (rec_count_q != '0) && slot_free;
    if (take) begin
      state_d = PRESENT;
    end else if (deliver) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rec_data_q     <= '0;
      rec_count_q    <= '0;
      starve_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        rec_data_q <= bus.fifo_data;
      end
      if (deliver && (rec_count_q != '1)) begin
        rec_count_q <= rec_count_q + 1'b1;
      end
      if (starve && (starve_count_q != '1)) begin
        starve_count_q <= starve_count_q + 1'b1;
      end
    end
  end

  assign bus.fifo_read_en = take;
  assign bus.rec_valid    = (state_q == PRESENT);
  assign bus.rec_data     = rec_data_q;
  assign busy             = (state_q == PRESENT);
  assign rec_count        = rec_count_q;
  assign starve_count     = starve_count_q;
endmodule
